// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in EX.
// Holds the front of the pipeline via indication until the result is presented.
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic            kill,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            indication,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_rem_q, sel_rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   a_orig_q, a_orig_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              div0_q, div0_d;
    logic              ovf_q, ovf_d;

    logic              is_signed;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              b_zero;
    logic              ovf_in;
    logic              accept;

    logic [XLEN:0]     partial;
    logic [XLEN:0]     trial;
    logic              fits;
    logic [XLEN-1:0]   rem_step;
    logic [XLEN-1:0]   quo_step;

    logic [XLEN-1:0]   quo_signed;
    logic [XLEN-1:0]   rem_signed;

    // op[0] set means unsigned; sign flags are forced low for DIVU/REMU.
    assign is_signed = ~op[0];
    assign sign_a    = is_signed & operand_a[XLEN-1];
    assign sign_b    = is_signed & operand_b[XLEN-1];
    assign abs_a     = sign_a ? (~operand_a + 1'b1) : operand_a;
    assign abs_b     = sign_b ? (~operand_b + 1'b1) : operand_b;
    assign b_zero    = (operand_b == '0);
    assign ovf_in    = is_signed
                     & (operand_a == {1'b1, {(XLEN-1){1'b0}}})
                     & (operand_b == {XLEN{1'b1}});
    assign accept    = start & ~kill;

    // The partial remainder keeps its top bit so unsigned divisors >= 2^(XLEN-1) divide correctly.
    assign partial   = {rem_q, quo_q[XLEN-1]};
    assign trial     = partial - {1'b0, dvs_q};
    assign fits      = ~trial[XLEN];
    assign rem_step  = fits ? trial[XLEN-1:0] : partial[XLEN-1:0];
    assign quo_step  = {quo_q[XLEN-2:0], fits};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sel_rem_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            a_orig_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_rem_q <= sel_rem_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            a_orig_q  <= a_orig_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_rem_d    = sel_rem_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        dvs_d        = dvs_q;
        a_orig_d     = a_orig_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        div0_d       = div0_q;
        ovf_d        = ovf_q;
        indication   = 1'b0;
        result_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                indication = accept;
                if (accept) begin
                    sel_rem_d = op[1];
                    quo_d     = abs_a;
                    rem_d     = '0;
                    dvs_d     = abs_b;
                    a_orig_d  = operand_a;
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    div0_d    = b_zero;
                    ovf_d     = ovf_in;
                    cnt_d     = CNT_W'(XLEN - 1);
                    state_d   = (b_zero | ovf_in) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                indication = 1'b1;
                quo_d      = quo_step;
                rem_d      = rem_step;
                cnt_d      = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (kill) begin
            state_d = S_IDLE;
        end
    end

    assign quo_signed = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    assign rem_signed = neg_rem_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        result = '0;
        if (state_q == S_DONE) begin
            if (div0_q) begin
                result = sel_rem_q ? a_orig_q : {XLEN{1'b1}};
            end else if (ovf_q) begin
                result = sel_rem_q ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end else begin
                result = sel_rem_q ? rem_signed : quo_signed;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner
// sequences (reset, kill, back-to-back, start drop) and randomized ops vs. an arithmetic model.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        kill;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        indication;
    logic        result_valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc_g  = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .kill         (kill),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .indication   (indication),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules.
    function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        if (o[0]) return o[1] ? (a % b) : (a / b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Present one divide, hold start until the result cycle, then retire it.
    task automatic run_div(input string nm, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int  cyc;
        int  ind_cnt;
        bit  seen;
        bit  bad_idle_res;
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        #1;
        cyc = 0; ind_cnt = 0; seen = 0; bad_idle_res = 0;
        while (cyc < 45 && !seen) begin
            if (result_valid) begin
                seen = 1;
                check({nm, " result"}, result, exp_res);
                check({nm, " latency"}, cyc, exp_lat);
                check({nm, " ind_in_done"}, {31'd0, indication}, 32'd0);
            end else begin
                if (indication) ind_cnt++;
                if (result !== 32'd0) bad_idle_res = 1;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout got=no_valid exp=valid", nm);
        end
        check({nm, " ind_cycles"}, ind_cnt, exp_lat);
        check({nm, " result_zero_when_invalid"}, {31'd0, bad_idle_res}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input string nm, input int maxc);
        int n;
        n = 0;
        while (!result_valid && n < maxc) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!result_valid) begin
            errors++;
            $display("FAIL %s timeout got=no_valid exp=valid", nm);
        end
    endtask

    initial begin
        int t1;
        int t2;
        int nvalid;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          mode;

        vecs.push_back('{2'b01, 32'd100,        32'd7,          32'd14,         33});
        vecs.push_back('{2'b11, 32'd100,        32'd7,          32'd2,          33});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33});
        vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33});
        vecs.push_back('{2'b00, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678,  1});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33});
        vecs.push_back('{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          33});
        vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33});
        vecs.push_back('{2'b10, 32'd0,          32'd0,          32'd0,          1});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  33});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1});
        vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33});

        reset = 1'b1; start = 1'b0; op = 2'b00; kill = 1'b0;
        operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset indication", {31'd0, indication}, 32'd0);
        check("reset result_valid", {31'd0, result_valid}, 32'd0);
        check("reset result", result, 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_div($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
        end

        // Reset during CALC aborts; the next divide still completes.
        start = 1'b1; op = 2'b01; operand_a = 32'd1000; operand_b = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b1; start = 1'b0;
        #1;
        check("midreset indication", {31'd0, indication}, 32'd0);
        check("midreset result_valid", {31'd0, result_valid}, 32'd0);
        check("midreset result", result, 32'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        check("after reset no valid", {31'd0, result_valid}, 32'd0);
        run_div("post_reset divu", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        // kill in CALC cycle 5: indication holds this cycle, no result ever appears.
        start = 1'b1; op = 2'b01; operand_a = 32'd12345; operand_b = 32'd7;
        repeat (5) begin @(posedge clk); #1; end
        kill = 1'b1;
        #1;
        check("kill calc indication", {31'd0, indication}, 32'd1);
        @(posedge clk); #1;
        kill = 1'b0; start = 1'b0;
        #1;
        check("kill next idle indication", {31'd0, indication}, 32'd0);
        nvalid = 0;
        repeat (40) begin
            if (result_valid) nvalid++;
            @(posedge clk); #1;
        end
        check("kill no valid", nvalid, 0);

        // kill in IDLE blocks acceptance.
        start = 1'b1; kill = 1'b1; op = 2'b01; operand_a = 32'd50; operand_b = 32'd0;
        #1;
        check("kill idle indication", {31'd0, indication}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("kill idle no valid", {31'd0, result_valid}, 32'd0);
        start = 1'b0; kill = 1'b0;
        @(posedge clk); #1;

        // Back-to-back: start stays high through DONE and straight into the next op.
        start = 1'b1; op = 2'b01; operand_a = 32'd20; operand_b = 32'd4;
        #1;
        wait_valid("b2b first", 45);
        t1 = cyc_g;
        check("b2b first result", result, 32'd5);
        @(posedge clk); #1;
        operand_a = 32'd21;
        #1;
        check("b2b second accept indication", {31'd0, indication}, 32'd1);
        @(posedge clk); #1;
        wait_valid("b2b second", 45);
        t2 = cyc_g;
        check("b2b second result", result, 32'd5);
        check("b2b spacing", t2 - t1, 34);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;

        // start dropping mid-CALC is ignored.
        start = 1'b1; op = 2'b01; operand_a = 32'd1000; operand_b = 32'd7;
        t1 = cyc_g;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b0;
        #1;
        wait_valid("start drop", 45);
        check("start drop result", result, 32'd142);
        check("start drop latency", cyc_g - t1, 33);
        @(posedge clk); #1;

        for (int k = 0; k < 150; k++) begin
            ro   = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 9);
            ra   = $urandom;
            rb   = $urandom;
            if (mode == 0) rb = 32'd0;
            else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (mode == 2) rb = 32'($urandom_range(1, 15));
            else if (mode == 3) ra = 32'($urandom_range(0, 100));
            run_div($sformatf("rand%0d op%0d a=%h b=%h", k, ro, ra, rb), ro, ra, rb,
                    ref_res(ro, ra, rb), ref_lat(ro, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

endmodule
